game_countdown_timer: RTL and testbench

//  Consumer end of the one-second tick interface. Takes the periodic one_sec strobe from the

---
 rtl/game_timer_pkg.sv | 21 ++
 rtl/timer_bcd_alu.sv | 82 ++++++++
 rtl/game_countdown_timer.sv | 111 +++++++++++
 tb/tb_game_countdown_timer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_timer_pkg.sv
// Shared types for the game-round countdown timer: FSM states and two-digit BCD time values.
package game_timer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} timer_state_t;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t tens;
        bcd_digit_t ones;
    } bcd2_t;

    // Turns a decimal parameter (0..99) into its two BCD digits.
    function automatic bcd2_t to_bcd2(input int value);
        bcd2_t result;
        result.tens = bcd_digit_t'(value / 10);
        result.ones = bcd_digit_t'(value % 10);
        return result;
    endfunction

endpackage

// File: rtl/timer_bcd_alu.sv
// Combinational two-digit BCD unit: optional add, then optional decrement, then clamp to a ceiling.
module timer_bcd_alu
    import game_timer_pkg::*;
(
    input  bcd2_t value,
    input  logic  dec,
    input  logic  add_en,
    input  bcd2_t add_val,
    input  bcd2_t max_val,
    output bcd2_t next_val,
    output logic  zero
);

    logic [4:0] ones_sum;
    logic [4:0] ones_adj;
    logic [4:0] tens_sum;
    logic [4:0] tens_adj;
    logic       carry;
    logic       hund;
    bcd_digit_t s_tens;
    bcd_digit_t s_ones;
    logic       d_hund;
    bcd_digit_t d_tens;
    bcd_digit_t d_ones;

    // The sum keeps a hundreds bit so that add-then-decrement is exact before clamping.
    always_comb begin
        ones_sum = 5'd0;
        ones_adj = 5'd0;
        tens_sum = 5'd0;
        tens_adj = 5'd0;
        carry    = 1'b0;
        hund     = 1'b0;
        s_tens   = value.tens;
        s_ones   = value.ones;
        if (add_en) begin
            ones_sum = {1'b0, value.ones} + {1'b0, add_val.ones};
            ones_adj = ones_sum - 5'd10;
            if (ones_sum > 5'd9) begin
                s_ones = ones_adj[3:0];
                carry  = 1'b1;
            end else begin
                s_ones = ones_sum[3:0];
            end
            tens_sum = {1'b0, value.tens} + {1'b0, add_val.tens} + {4'b0000, carry};
            tens_adj = tens_sum - 5'd10;
            if (tens_sum > 5'd9) begin
                s_tens = tens_adj[3:0];
                hund   = 1'b1;
            end else begin
                s_tens = tens_sum[3:0];
            end
        end

        d_hund = hund;
        d_tens = s_tens;
        d_ones = s_ones;
        if (dec && (hund || s_tens != 4'd0 || s_ones != 4'd0)) begin
            if (s_ones != 4'd0) begin
                d_ones = s_ones - 4'd1;
            end else begin
                d_ones = 4'd9;
                if (s_tens != 4'd0) begin
                    d_tens = s_tens - 4'd1;
                end else begin
                    d_tens = 4'd9;
                    d_hund = 1'b0;
                end
            end
        end

        if (d_hund || d_tens > max_val.tens ||
            (d_tens == max_val.tens && d_ones > max_val.ones)) begin
            next_val = max_val;
        end else begin
            next_val.tens = d_tens;
            next_val.ones = d_ones;
        end
        zero = (next_val.tens == 4'd0) && (next_val.ones == 4'd0);
    end

endmodule

// File: rtl/game_countdown_timer.sv
// Game-round countdown: consumes the one-second strobe and runs a BCD timer with pause,
// bonus time, low-time warning and time-up reporting.
module game_countdown_timer
    import game_timer_pkg::*;
#(
    parameter int START_SEC = 60,
    parameter int MAX_SEC   = 99,
    parameter int BONUS_SEC = 5,
    parameter int WARN_SEC  = 10
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       one_sec,
    input  logic       start,
    input  logic       pause_toggle,
    input  logic       add_bonus,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       running,
    output logic       warning,
    output logic       time_up,
    output logic       time_up_pulse
);

    localparam bcd2_t START_BCD = to_bcd2(START_SEC);
    localparam bcd2_t MAX_BCD   = to_bcd2(MAX_SEC);
    localparam bcd2_t BONUS_BCD = to_bcd2(BONUS_SEC);

    timer_state_t state, state_n;
    bcd2_t        time_val, time_n;
    logic         one_sec_d;
    logic         pulse_n;
    logic         tick;
    logic         alu_dec;
    logic         alu_add;
    bcd2_t        alu_next;
    logic         alu_zero;
    logic [6:0]   time_bin;

    assign tick = one_sec & ~one_sec_d;

    // start and pause_toggle pre-empt the arithmetic, so the ALU only sees surviving requests.
    assign alu_dec = (state == RUN) && tick && !start && !pause_toggle;
    assign alu_add = (state == RUN || state == PAUSED) && add_bonus && !start && !pause_toggle;

    timer_bcd_alu u_alu (
        .value    (time_val),
        .dec      (alu_dec),
        .add_en   (alu_add),
        .add_val  (BONUS_BCD),
        .max_val  (MAX_BCD),
        .next_val (alu_next),
        .zero     (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state         <= IDLE;
            time_val      <= START_BCD;
            one_sec_d     <= 1'b0;
            time_up_pulse <= 1'b0;
        end else begin
            state         <= state_n;
            time_val      <= time_n;
            one_sec_d     <= one_sec;
            time_up_pulse <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        time_n  = time_val;
        pulse_n = 1'b0;
        if (start) begin
            state_n = RUN;
            time_n  = START_BCD;
        end else begin
            case (state)
                RUN: begin
                    if (pause_toggle) begin
                        state_n = PAUSED;
                    end else if (alu_dec || alu_add) begin
                        time_n = alu_next;
                        // A bonus in the same cycle always leaves time above zero.
                        if (alu_dec && !alu_add && alu_zero) begin
                            state_n = EXPIRED;
                            pulse_n = 1'b1;
                        end
                    end
                end
                PAUSED: begin
                    if (pause_toggle) begin
                        state_n = RUN;
                    end else if (alu_add) begin
                        time_n = alu_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign time_bin = ({3'b000, time_val.tens} * 7'd10) + {3'b000, time_val.ones};

    assign tens    = time_val.tens;
    assign ones    = time_val.ones;
    assign running = (state == RUN);
    assign time_up = (state == EXPIRED);
    assign warning = (state != IDLE) && (time_bin != 7'd0) && (time_bin <= 7'(WARN_SEC));

endmodule

// File: tb/tb_game_countdown_timer.sv
// Directed self-checking bench for game_countdown_timer with default parameters (60/99/5/10).
module tb_game_countdown_timer;

    logic       clk;
    logic       resetN;
    logic       one_sec;
    logic       start;
    logic       pause_toggle;
    logic       add_bonus;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       running;
    logic       warning;
    logic       time_up;
    logic       time_up_pulse;

    int checks = 0;
    int errors = 0;

    game_countdown_timer dut (
        .clk           (clk),
        .resetN        (resetN),
        .one_sec       (one_sec),
        .start         (start),
        .pause_toggle  (pause_toggle),
        .add_bonus     (add_bonus),
        .tens          (tens),
        .ones          (ones),
        .running       (running),
        .warning       (warning),
        .time_up       (time_up),
        .time_up_pulse (time_up_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick_once();
        one_sec = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick_once();
    endtask

    task automatic press(input int which);
        if (which == 0) start = 1'b1;
        if (which == 1) pause_toggle = 1'b1;
        if (which == 2) add_bonus = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pause_toggle = 1'b0;
        add_bonus = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        start = 1'b1;
        one_sec = 1'b0;
        pause_toggle = 1'b0;
        add_bonus = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b0;
        resetN = 1'b1;
        checks++;
        if ({tens, ones} !== 8'h60) begin
            errors++;
            $display("[TB] FAIL reset_digits: got %h want 60", {tens, ones});
        end
        checks++;
        if ({running, warning, time_up, time_up_pulse} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b want 0000", {running, warning, time_up, time_up_pulse});
        end
        ticks(2);
        checks++;
        if ({tens, ones, running} !== 9'h0C0) begin
            errors++;
            $display("[TB] FAIL idle_ignores_tick: got %h want 0c0", {tens, ones, running});
        end
    endtask

    task automatic test_countdown();
        press(0);
        checks++;
        if ({tens, ones, running} !== 9'h0C1) begin
            errors++;
            $display("[TB] FAIL start_load: got %h want 0c1", {tens, ones, running});
        end
        tick_once();
        checks++;
        if ({tens, ones} !== 8'h59) begin
            errors++;
            $display("[TB] FAIL borrow_59: got %h want 59", {tens, ones});
        end
        tick_once();
        tick_once();
        checks++;
        if ({tens, ones, running} !== 9'h0AF) begin
            errors++;
            $display("[TB] FAIL count_57: got %h want 0af", {tens, ones, running});
        end
    endtask

    task automatic test_held_tick();
        one_sec = 1'b1;
        repeat (20) @(negedge clk);
        one_sec = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens, ones} !== 8'h56) begin
            errors++;
            $display("[TB] FAIL held_tick: got %h want 56", {tens, ones});
        end
    endtask

    task automatic test_bonus();
        for (int i = 0; i < 8; i++) press(2);
        checks++;
        if ({tens, ones} !== 8'h96) begin
            errors++;
            $display("[TB] FAIL bonus_carry: got %h want 96", {tens, ones});
        end
        tick_once();
        press(2);
        checks++;
        if ({tens, ones} !== 8'h99) begin
            errors++;
            $display("[TB] FAIL bonus_saturate: got %h want 99", {tens, ones});
        end
        one_sec = 1'b1;
        add_bonus = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
        add_bonus = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens, ones} !== 8'h99) begin
            errors++;
            $display("[TB] FAIL tick_bonus_saturate: got %h want 99", {tens, ones});
        end
        ticks(88);
        checks++;
        if ({tens, ones, running, warning} !== 10'h046) begin
            errors++;
            $display("[TB] FAIL at_11: got %h want 046", {tens, ones, running, warning});
        end
        one_sec = 1'b1;
        add_bonus = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
        add_bonus = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens, ones} !== 8'h15) begin
            errors++;
            $display("[TB] FAIL tick_plus_bonus: got %h want 15", {tens, ones});
        end
    endtask

    task automatic test_pause();
        press(2);
        press(1);
        checks++;
        if ({tens, ones, running} !== 9'h040) begin
            errors++;
            $display("[TB] FAIL pause_enter: got %h want 040", {tens, ones, running});
        end
        ticks(5);
        checks++;
        if ({tens, ones} !== 8'h20) begin
            errors++;
            $display("[TB] FAIL pause_frozen: got %h want 20", {tens, ones});
        end
        press(2);
        checks++;
        if ({tens, ones} !== 8'h25) begin
            errors++;
            $display("[TB] FAIL pause_bonus: got %h want 25", {tens, ones});
        end
        press(1);
        tick_once();
        checks++;
        if ({tens, ones, running} !== 9'h049) begin
            errors++;
            $display("[TB] FAIL resume: got %h want 049", {tens, ones, running});
        end
        one_sec = 1'b1;
        pause_toggle = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
        pause_toggle = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens, ones, running} !== 9'h048) begin
            errors++;
            $display("[TB] FAIL pause_beats_tick: got %h want 048", {tens, ones, running});
        end
        press(1);
    endtask

    task automatic test_expire();
        ticks(23);
        checks++;
        if ({tens, ones, running, warning, time_up} !== 11'h00E) begin
            errors++;
            $display("[TB] FAIL at_01: got %h want 00e", {tens, ones, running, warning, time_up});
        end
        one_sec = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
        checks++;
        if ({tens, ones, running, warning, time_up, time_up_pulse} !== 12'h003) begin
            errors++;
            $display("[TB] FAIL expire_entry: got %h want 003", {tens, ones, running, warning, time_up, time_up_pulse});
        end
        @(negedge clk);
        checks++;
        if ({time_up, time_up_pulse} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL pulse_one_cycle: got %b want 10", {time_up, time_up_pulse});
        end
        ticks(3);
        press(2);
        press(1);
        checks++;
        if ({tens, ones, running, time_up, time_up_pulse} !== 11'h002) begin
            errors++;
            $display("[TB] FAIL expired_frozen: got %h want 002", {tens, ones, running, time_up, time_up_pulse});
        end
        press(0);
        checks++;
        if ({tens, ones, running, time_up} !== 10'h182) begin
            errors++;
            $display("[TB] FAIL restart: got %h want 182", {tens, ones, running, time_up});
        end
    endtask

    task automatic test_back_to_back();
        press(1);
        press(1);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("[TB] FAIL double_toggle: got %b want 1", running);
        end
        tick_once();
        start = 1'b1;
        pause_toggle = 1'b1;
        one_sec = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pause_toggle = 1'b0;
        one_sec = 1'b0;
        @(negedge clk);
        checks++;
        if ({tens, ones, running} !== 9'h0C1) begin
            errors++;
            $display("[TB] FAIL start_priority: got %h want 0c1", {tens, ones, running});
        end
    endtask

    task automatic test_reset_mid_run();
        ticks(18);
        checks++;
        if ({tens, ones} !== 8'h42) begin
            errors++;
            $display("[TB] FAIL at_42: got %h want 42", {tens, ones});
        end
        resetN = 1'b0;
        one_sec = 1'b1;
        @(negedge clk);
        resetN = 1'b1;
        one_sec = 1'b0;
        checks++;
        if ({tens, ones, running, warning, time_up, time_up_pulse} !== 12'h600) begin
            errors++;
            $display("[TB] FAIL reset_mid_run: got %h want 600", {tens, ones, running, warning, time_up, time_up_pulse});
        end
    endtask

    initial begin
        resetN = 1'b0;
        one_sec = 1'b0;
        start = 1'b0;
        pause_toggle = 1'b0;
        add_bonus = 1'b0;
        @(negedge clk);
        test_reset();
        test_countdown();
        test_held_tick();
        test_bonus();
        test_pause();
        test_expire();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

endmodule
